// File: rtl/padc_pkg.sv
// Shared types and constants for the pipelined-ADC digital back-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package padc_pkg;

   localparam int N_STAGES_DEF = 7;

   typedef logic [1:0] raw_t;

   localparam raw_t RAW_M1  = 2'd0;
   localparam raw_t RAW_Z   = 2'd1;
   localparam raw_t RAW_P1  = 2'd2;
   localparam raw_t RAW_ILL = 2'd3;

   typedef logic [N_STAGES_DEF:0] code_t;

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   // An illegal decision is treated as +1 so one bad comparator cannot wrap the code.
   function automatic raw_t fix_raw(input raw_t r);
      raw_t m;
      unique case (r)
         RAW_M1:  m = RAW_M1;
         RAW_Z:   m = RAW_Z;
         default: m = RAW_P1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/padc_code_fifo.sv
// Generic synchronous FIFO with a drop strobe for writes that find it full.
// Latency: a pushed word is visible at dout one edge after the push.
// Backpressure: push while full is accepted only if a pop happens on the same edge, else dropped.
module padc_code_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign drop    = push & full & ~pop_ok;
   assign dout    = mem[rd_ptr];

   // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/padc_dig_ctrl.sv
// Pipelined-ADC back-end: aligns stage decisions, corrects to one code per sample, queues codes (PADC_ERR_CNT_EN adds err_cnt).
// Latency: first code is valid 8 edges after conv_en is first sampled high (that edge included), FIFO empty.
// Backpressure: code_valid/code_ready FIFO; a code produced while the FIFO is full is dropped and ovf_sticky set.
module padc_dig_ctrl
   import padc_pkg::*;
#(
   parameter int N_STAGES   = N_STAGES_DEF,
   parameter int FIFO_DEPTH = 4
`ifdef PADC_ERR_CNT_EN
   ,
   parameter int ERR_W      = 8
`endif
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              conv_en,
   input  raw_t              dig_raw [N_STAGES],
   output logic [N_STAGES:0] code,
   output logic              code_valid,
   input  logic              code_ready,
   output logic              busy,
   output logic              ovf_sticky,
   input  logic              ovf_clr
`ifdef PADC_ERR_CNT_EN
   ,
   output logic [ERR_W-1:0]  err_cnt
`endif
);

   localparam int CW    = N_STAGES + 1;
   localparam int CNT_W = $clog2(N_STAGES);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(N_STAGES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] fill_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             push_req;
   raw_t             aln [N_STAGES];
   logic [CW-1:0]    corr;
   logic             fifo_empty;
   logic             fifo_drop;
   // Overflow is reported through the drop strobe, so full is not needed here.
   logic             fifo_full_unused;

   // Stage i resolves i edges after stage 0, so it gets N_STAGES-i delays to line up with stage 0.
   for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_aln
      localparam int LEN = N_STAGES - gi;
      raw_t sr [LEN];

      // Free-running delay line, independent of the FSM state.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            for (int k = 0; k < LEN; k++) sr[k] <= RAW_M1;
         end else begin
            sr[0] <= fix_raw(dig_raw[gi]);
            for (int k = 1; k < LEN; k++) sr[k] <= sr[k-1];
         end
      end

      assign aln[gi] = sr[LEN-1];
   end

   // Redundant-digit correction: weighted sum of the aligned digits (max 2^CW-2, never overflows).
   always_comb begin
      corr = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         corr = corr + (CW'(aln[i]) << (N_STAGES - 1 - i));
      end
   end

   // Conversion FSM state and fill counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         fill_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fill_cnt <= cnt_nxt;
      end
   end

   // Next state: FILL waits until the delay lines hold the first complete sample, RUN pushes every edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = fill_cnt;
      push_req  = 1'b0;
      unique case (state)
         IDLE: begin
            if (conv_en) begin
               state_nxt = FILL;
               cnt_nxt   = '0;
            end
         end
         FILL: begin
            cnt_nxt = fill_cnt + CNT_W'(1);
            if (!conv_en)                  state_nxt = IDLE;
            else if (cnt_nxt == FILL_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (conv_en) push_req  = 1'b1;
            else         state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign code_valid = ~fifo_empty;

   padc_code_fifo #(
      .W     (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push_req),
      .pop   (code_ready),
      .din   (corr),
      .dout  (code),
      .full  (fifo_full_unused),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   // Sticky overflow flag; a new drop beats a clear on the same edge.
   always_ff @(posedge clk) begin
      if (!rstn)          ovf_sticky <= 1'b0;
      else if (fifo_drop) ovf_sticky <= 1'b1;
      else if (ovf_clr)   ovf_sticky <= 1'b0;
   end

`ifdef PADC_ERR_CNT_EN
   localparam int IW = $clog2(N_STAGES + 1);

   logic [IW-1:0]  ill_n;
   logic [ERR_W:0] err_sum;

   // Count illegal decisions presented this edge and form the unsaturated next count.
   always_comb begin
      ill_n = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (dig_raw[i] == RAW_ILL) ill_n = ill_n + IW'(1);
      end
      err_sum = {1'b0, err_cnt} + (ERR_W+1)'(ill_n);
   end

   // Saturating error counter, only advancing while a conversion is in progress.
   always_ff @(posedge clk) begin
      if (!rstn)     err_cnt <= '0;
      else if (busy) err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
   end
`endif

endmodule

// File: tb/tb_padc_dig_ctrl.sv
// Self-checking bench for padc_dig_ctrl against a sample-history reference model.
// Latency: n/a.
// Backpressure: exercised through code_ready patterns and overflow.
module tb_padc_dig_ctrl;
   import padc_pkg::*;

   localparam int NS     = 7;
   localparam int DEPTH  = 4;
   localparam int MAXE   = 4096;
   localparam int ERRMAX = 255;

   logic        clk;
   logic        rstn;
   logic        conv_en;
   raw_t        dig_raw [NS];
   logic [NS:0] code;
   logic        code_valid;
   logic        code_ready;
   logic        busy;
   logic        ovf_sticky;
   logic        ovf_clr;
`ifdef PADC_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   int   total;
   int   bad;
   raw_t hist [MAXE][NS];
   int   ek;
   int   streak;
   int   m_err;
   bit   m_busy;
   bit   m_ovf;
   int   q[$];
   int   pops[$];

   padc_dig_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .conv_en    (conv_en),
      .dig_raw    (dig_raw),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .busy       (busy),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
`ifdef PADC_ERR_CNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Code of the sample whose stage-0 decision was captured at edge t:
   // stage i of that sample is the decision captured at edge t+i, weighted 2^(NS-1-i).
   function automatic int exp_code(input int t);
      int s;
      int d;
      s = 0;
      for (int i = 0; i < NS; i++) begin
         d = int'(hist[t+i][i]);
         if (d == 3) d = 2;
         s += d * (1 << (NS - 1 - i));
      end
      return s;
   endfunction

   task automatic set_all(input int v);
      for (int i = 0; i < NS; i++) dig_raw[i] = raw_t'(v);
   endtask

   task automatic rand_raw(input int maxv);
      for (int i = 0; i < NS; i++) dig_raw[i] = raw_t'($urandom_range(maxv, 0));
   endtask

   // One clock edge: capture inputs, advance the reference model, then check outputs #1 later.
   task automatic step();
      raw_t r [NS];
      logic ce, rs, rdy, clr;
      bit   pop_m, push_m, dropped;
      int   nill;
      ce  = conv_en;
      rs  = rstn;
      rdy = code_ready;
      clr = ovf_clr;
      r   = dig_raw;
      if (code_valid === 1'b1 && code_ready) pops.push_back(int'(code));
      if (ek >= MAXE) begin
         $display("FAIL hist_overflow observed=%0d expected<%0d", ek, MAXE);
         $fatal(1, "history table exhausted");
      end
      @(posedge clk);
      hist[ek] = r;
      if (!rs) begin
         streak = 0;
         q.delete();
         m_ovf  = 1'b0;
         m_err  = 0;
         m_busy = 1'b0;
      end else begin
         nill = 0;
         for (int i = 0; i < NS; i++) if (r[i] == 2'd3) nill++;
         if (m_busy) m_err = (m_err + nill > ERRMAX) ? ERRMAX : m_err + nill;
         // A code is produced once conv_en has been sampled high on 8 consecutive edges.
         streak  = ce ? streak + 1 : 0;
         pop_m   = (q.size() > 0) && rdy;
         push_m  = (streak >= NS + 1);
         dropped = 1'b0;
         if (pop_m) void'(q.pop_front());
         if (push_m) begin
            if (q.size() < DEPTH) q.push_back(exp_code(ek - NS));
            else                  dropped = 1'b1;
         end
         if (dropped)  m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         m_busy = ce;
      end
      ek++;
      #1;
      chk("code_valid", 32'(code_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("code", 32'(code), 32'(q[0]));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
`ifdef PADC_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic latency_check(input string tag);
      int lat;
      lat = 0;
      do begin
         step();
         lat++;
      end while (code_valid !== 1'b1 && lat < 20);
      chk(tag, 32'(lat), 32'd8);
   endtask

   initial begin
      int n254;
      int nbad;
      total = 0; bad = 0; ek = 0; streak = 0; m_err = 0; m_busy = 0; m_ovf = 0;
      rstn = 1'b0; conv_en = 1'b0; code_ready = 1'b1; ovf_clr = 1'b0;
      set_all(1);
      #2;

      // Reset state
      steps(2);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_valid", 32'(code_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      steps(2);

      // All stages at 0 decision (raw=1): fill latency and mid-scale code
      conv_en = 1'b1;
      latency_check("lat_first");
      chk("all1_code", 32'(code), 32'd127);
      steps(5);
      chk("all1_busy", 32'(busy), 32'd1);
      conv_en = 1'b0;
      steps(3);
      chk("idle_busy", 32'(busy), 32'd0);

      // All +1 and all -1
      set_all(2);
      conv_en = 1'b1;
      steps(10);
      chk("all2_code", 32'(code), 32'd254);
      conv_en = 1'b0;
      steps(3);
      set_all(0);
      conv_en = 1'b1;
      steps(10);
      chk("all0_code", 32'(code), 32'd0);
      conv_en = 1'b0;
      steps(3);

      // Diagonal pulse: one sample sees +1 at every stage
      set_all(1);
      conv_en = 1'b1;
      steps(10);
      pops.delete();
      for (int j = 0; j < NS; j++) begin
         for (int i = 0; i < NS; i++) dig_raw[i] = (i == j) ? RAW_P1 : RAW_Z;
         step();
      end
      set_all(1);
      steps(12);
      conv_en = 1'b0;
      steps(4);
      n254 = 0; nbad = 0;
      foreach (pops[k]) begin
         if (pops[k] == 254)      n254++;
         else if (pops[k] != 127) nbad++;
      end
      chk("diag_254", 32'(n254), 32'd1);
      chk("diag_other", 32'(nbad), 32'd0);

      // Overflow with code_ready held low, clear priority, then drain
      code_ready = 1'b0;
      conv_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         rand_raw(2);
         step();
      end
      chk("ovf_set", 32'(ovf_sticky), 32'd1);
      ovf_clr = 1'b1;
      step();
      chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
      conv_en = 1'b0;
      step();
      chk("ovf_cleared", 32'(ovf_sticky), 32'd0);
      ovf_clr = 1'b0;
      pops.delete();
      code_ready = 1'b1;
      steps(6);
      chk("drain_count", 32'(pops.size()), 32'd4);
      chk("drain_empty", 32'(code_valid), 32'd0);

      // Illegal decision on stage 3 for two edges while busy
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      rand_raw(2);
      conv_en = 1'b1;
      steps(9);
      for (int k = 0; k < 2; k++) begin
         rand_raw(2);
         dig_raw[3] = RAW_ILL;
         step();
      end
      for (int k = 0; k < 12; k++) begin
         rand_raw(2);
         step();
      end
      conv_en = 1'b0;
      steps(3);
`ifdef PADC_ERR_CNT_EN
      chk("err_two", 32'(err_cnt), 32'd2);
`endif

      // Reset mid-RUN with three queued codes
      code_ready = 1'b0;
      conv_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rand_raw(3);
         step();
      end
      chk("pre_rst_valid", 32'(code_valid), 32'd1);
      rstn = 1'b0;
      step();
      chk("mid_rst_valid", 32'(code_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ovf", 32'(ovf_sticky), 32'd0);
      rstn = 1'b1;
      code_ready = 1'b1;
      latency_check("lat_restart");
      conv_en = 1'b0;
      steps(3);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(15, 0) == 0) conv_en = ~conv_en;
         code_ready = ($urandom_range(3, 0) != 0);
         ovf_clr    = ($urandom_range(19, 0) == 0);
         rstn       = ($urandom_range(199, 0) != 0);
         rand_raw(3);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
